// File: rtl/bcd_scan_display_if.sv
// Counter-to-display link: packed BCD count and carry in, multiplexed
// active-low 7-segment drive and sticky error flag out.
interface bcd_scan_display_if;
    logic [6:0] count_in;
    logic       carry_in;
    logic [6:0] seg_n;
    logic       dp_n;
    logic [1:0] dig_n;
    logic       err;

    modport master (
        output count_in, carry_in,
        input  seg_n, dp_n, dig_n, err
    );

    modport slave (
        input  count_in, carry_in,
        output seg_n, dp_n, dig_n, err
    );
endinterface

// File: rtl/bcd_scan_display.sv
// Two-digit multiplexed common-anode 7-segment driver for the mod-80 BCD count.
// Optional macro LZ_BLANK_EN blanks a leading zero in the tens slot.
module bcd_scan_display #(
    parameter int SCAN_DIV = 1000,
    parameter int DP_HOLD  = 4
) (
    input  logic                  clk,
    input  logic                  Rst_n,
    bcd_scan_display_if.slave     bus
);
    localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int FW = $clog2(DP_HOLD + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [FW-1:0] DP_LOAD  = FW'(DP_HOLD);

    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic          slot_q, slot_d;
    logic [6:0]    shadow_q, shadow_d;
    logic [FW-1:0] dp_frames_q, dp_frames_d;
    logic          err_q, err_d;
    logic [6:0]    seg_n_q, seg_n_d;
    logic          dp_n_q, dp_n_d;
    logic [1:0]    dig_n_q, dig_n_d;

    logic          slot_end;
    logic          frame_bnd;
    logic          blank;
    logic [3:0]    digit;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h06;
        endcase
        return s;
    endfunction

    assign slot_end  = (div_cnt_q == DIV_LAST);
    assign frame_bnd = slot_end && slot_q;

    // Scan timebase: wrap and slot toggle share one edge.
    always_comb begin
        div_cnt_d = slot_end ? '0 : div_cnt_q + 1'b1;
        slot_d    = slot_end ? ~slot_q : slot_q;
    end

    // Capture only at frame boundaries so a frame never tears.
    always_comb begin
        shadow_d = frame_bnd ? bus.count_in : shadow_q;
        err_d    = err_q | (frame_bnd && (bus.count_in[3:0] > 4'd9));
    end

    // Carry reload wins over the per-frame decrement.
    always_comb begin
        dp_frames_d = dp_frames_q;
        if (bus.carry_in)
            dp_frames_d = DP_LOAD;
        else if (frame_bnd && (dp_frames_q != '0))
            dp_frames_d = dp_frames_q - 1'b1;
    end

    assign blank = (div_cnt_q == '0);
    assign digit = slot_q ? {1'b0, shadow_q[6:4]} : shadow_q[3:0];

    // Output decode from the current state; registered below.
    always_comb begin
        seg_n_d = 7'h7F;
        dp_n_d  = 1'b1;
        dig_n_d = 2'b11;
        if (!blank) begin
            dig_n_d = slot_q ? 2'b01 : 2'b10;
            seg_n_d = seg_decode(digit);
`ifdef LZ_BLANK_EN
            if (slot_q && (shadow_q[6:4] == 3'd0))
                seg_n_d = 7'h7F;
`endif
            if (!slot_q && (dp_frames_q != '0))
                dp_n_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            div_cnt_q   <= '0;
            slot_q      <= 1'b0;
            shadow_q    <= '0;
            dp_frames_q <= '0;
            err_q       <= 1'b0;
            seg_n_q     <= 7'h7F;
            dp_n_q      <= 1'b1;
            dig_n_q     <= 2'b11;
        end else begin
            div_cnt_q   <= div_cnt_d;
            slot_q      <= slot_d;
            shadow_q    <= shadow_d;
            dp_frames_q <= dp_frames_d;
            err_q       <= err_d;
            seg_n_q     <= seg_n_d;
            dp_n_q      <= dp_n_d;
            dig_n_q     <= dig_n_d;
        end
    end

    assign bus.seg_n = seg_n_q;
    assign bus.dp_n  = dp_n_q;
    assign bus.dig_n = dig_n_q;
    assign bus.err   = err_q;
endmodule

// File: doc/bcd_scan_display.md
Name: bcd_scan_display

Overview:
Display stage directly downstream of the mod-80 BCD counter. It consumes the 7-bit packed BCD count (tens [6:4], ones [3:0]) and the counter's 1-cycle carry pulse. It drives a 2-digit multiplexed common-anode 7-segment display with registered, active-low outputs. The carry is shown as a decimal point held lit for a programmable number of refresh frames.

Parameters:
- SCAN_DIV, 1000: clk cycles per digit slot; legal range ≥ 2.
- DP_HOLD, 4: number of full frames the DP stays lit after a carry; legal range ≥ 1.

Ports:
- clk  in  1  system clock
- Rst_n  in  1  reset, asynchronous, active-low
- count_in  in  7  packed BCD count; [6:4] tens 0-7, [3:0] ones 0-9
- carry_in  in  1  1-cycle carry pulse from the counter
- seg_n  out  7  segments a..g on bits [0]..[6], active-low
- dp_n  out  1  decimal point, active-low
- dig_n  out  2  digit enables, active-low; [0] ones, [1] tens
- err  out  1  sticky flag: an illegal ones digit was captured

Behaviour:
Reset, applied asynchronously on Rst_n low:
- seg_n=7'h7F, dp_n=1, dig_n=2'b11, err=0.
- Internal: div_cnt=0, slot=0, shadow=0, dp_frames=0.

Scan timing:
- div_cnt counts 0..SCAN_DIV-1 and wraps to 0.
- On wrap, slot toggles: 0 = ones, 1 = tens.
- One frame = 2 slots = 2*SCAN_DIV cycles.
- Frame boundary = the cycle where div_cnt==SCAN_DIV-1 and slot==1.

Input capture:
- shadow <= count_in only at a frame boundary, so there is no tearing within a frame.
- count_in changes mid-frame do not affect the display.
- At that same edge, err <= err | (count_in[3:0] > 9).

Output timing:
- All outputs are registered.
- Output values in cycle t are decoded from div_cnt, slot, shadow and dp_frames as they stood in cycle t-1 (1-cycle latency).

Anti-ghost blanking:
- While the source div_cnt==0, dig_n=2'b11 and seg_n=7'h7F.
- Otherwise dig_n=2'b10 for slot 0 and 2'b01 for slot 1.

Segment decode (seg_n values):
- 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
- Ones digit 10-15 displays "E" = 7'h06.
- Tens is 3 bits and is always legal.

Decimal point:
- carry_in=1 sets dp_frames=DP_HOLD.
- Otherwise dp_frames decrements by 1 at each frame boundary while non-zero.
- A carry arriving on a frame-boundary cycle loads DP_HOLD; reload wins over decrement.
- A carry during the hold window reloads to DP_HOLD (no accumulation).
- dp_n=0 only in non-blanked ones-slot cycles while dp_frames!=0; otherwise dp_n=1.

Boundary conditions:
- div_cnt wrap and slot toggle occur on the same edge.
- Reset mid-slot restarts at slot 0, div_cnt 0.
- The display shows shadow=0 ("00") until the first frame boundary after reset.

Optional Feature:
Macro: LZ_BLANK_EN.
- Defined: when shadow[6:4]==0, the tens slot drives seg_n=7'h7F and dp_n=1. dig_n still sequences normally.
- Undefined: a tens digit of 0 displays 7'h40.

Test Plan:
- Reset: assert Rst_n=0 mid-scan → same cycle seg_n=7F, dig_n=11, dp_n=1, err=0. Release → first slot is ones.
- Scan: SCAN_DIV=4, hold count_in=7'h79 → from frame 2 onward:
  - ones slot: dig_n=10, seg_n=10 for 3 cycles;
  - tens slot: dig_n=01, seg_n=78 for 3 cycles;
  - one blank cycle (dig_n=11) before each slot;
  - frame period 8 cycles.
- No tearing: change count_in 7'h12→7'h34 mid-frame → digits keep showing 1/2 until the next frame boundary, then show 3/4.
- Carry: SCAN_DIV=4, DP_HOLD=2, one carry_in pulse → dp_n=0 in ones slots for exactly 2 frames, then 1. A second pulse during frame 2 extends the hold to 2 frames from that pulse.
- Illegal digit: count_in=7'h0C captured → ones seg_n=06 and err=1. err stays 1 after count_in returns to legal values, until reset.
- Leading zero: count_in=7'h05 → tens seg_n=7F with LZ_BLANK_EN defined, 40 without it.
